// File: rtl/instr_mem_slave.sv
// Instruction-memory responder for the fetch stage: one word per syn/ack handshake after a
// programmable wait, with burst/top-of-memory last signalling and a side preload write port.
module instr_mem_slave #(
  parameter int                IWIDTH      = 32,
  parameter int                AWIDTH      = 32,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_CYCLES = 1,
  parameter int                BURST_LEN   = 8,
  parameter logic [IWIDTH-1:0] NOP_WORD    = 32'h00000013
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              i_syn,
  input  logic [AWIDTH-1:0] i_addr,
  output logic [IWIDTH-1:0] o_instr,
  output logic              o_ack,
  output logic              o_last,
  output logic              o_misalign,
  output logic              o_busy,
  input  logic              i_wr_en,
  input  logic [AWIDTH-1:0] i_wr_addr,
  input  logic [IWIDTH-1:0] i_wr_data
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [3:0]        wait_cnt_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [AWIDTH-1:0] addr_reg;
  logic [IWIDTH-1:0] rd_data_reg;
  logic              have_data_reg;
  logic              oor_reg;

  logic [IWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] rd_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_oor;
  logic              capture;
  logic              last_next;
  logic              wr_oor;
  logic              wr_addr_unused;

  // With no wait states the beat is captured on the accepting edge, so read the live address.
  assign rd_addr   = (state_reg == IDLE) ? i_addr : addr_reg;
  assign rd_idx    = rd_addr[IDX_W+1:2];
  assign rd_oor    = |rd_addr[AWIDTH-1:IDX_W+2];
  assign last_next = (beat_cnt_reg == BEAT_W'(BURST_LEN - 1)) ||
                     (rd_idx == IDX_W'(DEPTH - 1)) || rd_oor;

  assign capture = i_syn && (((state_reg == IDLE) && (WAIT_CYCLES == 0)) ||
                             ((state_reg == WAIT) && (wait_cnt_reg == 4'd1)));

  assign wr_oor         = |i_wr_addr[AWIDTH-1:IDX_W+2];
  assign wr_addr_unused = ^i_wr_addr[1:0];

  // Block RAM: write port plus registered read; a same-edge write leaves the old word in the read.
  always_ff @(posedge f_clk) begin
    if (i_wr_en && !wr_oor)
      mem[i_wr_addr[IDX_W+1:2]] <= i_wr_data;
    if (capture)
      rd_data_reg <= mem[rd_idx];
  end

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      beat_cnt_reg  <= '0;
      addr_reg      <= '0;
      have_data_reg <= 1'b0;
      oor_reg       <= 1'b0;
      o_ack         <= 1'b0;
      o_last        <= 1'b0;
      o_misalign    <= 1'b0;
    end else begin
      o_ack      <= 1'b0;
      o_last     <= 1'b0;
      o_misalign <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_syn) begin
            addr_reg <= i_addr;
            if (WAIT_CYCLES == 0) begin
              state_reg <= RESP;
            end else begin
              wait_cnt_reg <= 4'(WAIT_CYCLES);
              state_reg    <= WAIT;
            end
          end else begin
            beat_cnt_reg <= '0;
          end
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg - 4'd1;
          if (!i_syn) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
          end else if (wait_cnt_reg == 4'd1) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          state_reg    <= IDLE;
          beat_cnt_reg <= o_last ? '0 : beat_cnt_reg + BEAT_W'(1);
        end
        default: state_reg <= IDLE;
      endcase

      if (capture) begin
        o_ack         <= 1'b1;
        o_last        <= last_next;
        o_misalign    <= |rd_addr[1:0];
        oor_reg       <= rd_oor;
        have_data_reg <= 1'b1;
      end
    end
  end

  // The RAM read register has no reset, so the output is held at zero until the first capture.
  assign o_instr = have_data_reg ? (oor_reg ? NOP_WORD : rd_data_reg) : '0;
  assign o_busy  = (state_reg != IDLE);

endmodule
